// File: rtl/sum_pipe_pkg.sv
// Shared types and defaults for the sum pipeline stages.
// Window state encoding, default widths and a constant-width helper.
package sum_pipe_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam int DATA_W_DEF = 8;
    localparam int COUNT_DEF  = 4;
    localparam int ACC_W_DEF  = 10;

    function automatic int clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r++;
        end
        return int'(r);
    endfunction

endpackage

// File: rtl/sum_window_accumulator_sat_adder.sv
// Accumulator adder: ACC_W + DATA_W -> ACC_W with carry-out reported as ovf.
// ACC_SATURATE_EN selects clamp-to-all-ones instead of modular wrap on overflow.
module sat_adder
    import sum_pipe_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    logic [ACC_W:0] full;

    always_comb begin
        full = {1'b0, a} + (ACC_W + 1)'(b);
        ovf  = full[ACC_W];
`ifdef ACC_SATURATE_EN
        // Once clamped, any further nonzero add overflows again, so the clamp holds.
        sum  = ovf ? '1 : full[ACC_W-1:0];
`else
        sum  = full[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/sum_window_accumulator.sv
// Collects COUNT samples over a valid/ready stream and emits window total, average and overflow.
// Overflow handling follows ACC_SATURATE_EN (saturate when defined, wrap otherwise).
module sum_window_accumulator
    import sum_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int COUNT  = COUNT_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [ACC_W-1:0]          out_sum,
    output logic [DATA_W-1:0]         out_avg,
    output logic                      out_ovf,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [clog2(COUNT)-1:0]   fill
);

    localparam int FILL_W = clog2(COUNT);
    localparam logic [0:0] ST_ACCUM = ACCUM;
    localparam logic [0:0] ST_HOLD  = HOLD;

    logic [0:0]       state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic             ovf_lat;
    logic             handshake;
    logic             last;

    assign in_ready  = (state == ST_ACCUM);
    assign handshake = in_valid & in_ready;
    assign last      = (fill == FILL_W'(COUNT - 1));

    sat_adder #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W)
    ) u_sat_adder (
        .a   (acc),
        .b   (in_data),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_ACCUM;
            acc       <= '0;
            fill      <= '0;
            ovf_lat   <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_avg   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (handshake) begin
                        acc     <= add_sum;
                        ovf_lat <= ovf_lat | add_ovf;
                        if (last) begin
                            // Result comes straight from the final add, not from acc.
                            out_sum   <= add_sum;
                            out_avg   <= DATA_W'(add_sum >> FILL_W);
                            out_ovf   <= ovf_lat | add_ovf;
                            out_valid <= 1'b1;
                            fill      <= '0;
                            state     <= ST_HOLD;
                        end else begin
                            fill <= fill + FILL_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        ovf_lat   <= 1'b0;
                        state     <= ST_ACCUM;
                    end
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_window_accumulator.sv
// Self-checking bench: two DUTs (ACC_W=10 and ACC_W=9) share one stimulus stream.
// A queue-based window model predicts every output each cycle; directed literals pin the model.
module tb_sum_window_accumulator;

    localparam int COUNT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;

    logic       in_ready_a, out_valid_a, out_ovf_a;
    logic [9:0] out_sum_a;
    logic [7:0] out_avg_a;
    logic [1:0] fill_a;

    logic       in_ready_b, out_valid_b, out_ovf_b;
    logic [8:0] out_sum_b;
    logic [7:0] out_avg_b;
    logic [1:0] fill_b;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sum_window_accumulator dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
        .out_sum(out_sum_a), .out_avg(out_avg_a), .out_ovf(out_ovf_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .fill(fill_a)
    );

    sum_window_accumulator #(.ACC_W(9)) dut9 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
        .out_sum(out_sum_b), .out_avg(out_avg_b), .out_ovf(out_ovf_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .fill(fill_b)
    );

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Window model: samples accepted so far, plus expected registered results per width.
    int unsigned q[$];
    bit          m_hold = 1'b0;
    bit          m_valid = 1'b0;
    int unsigned m_sum[2];
    int unsigned m_avg[2];
    int unsigned m_ovf[2];

    function automatic void calc(input int unsigned total, input int unsigned w,
                                 output int unsigned s, output int unsigned a,
                                 output int unsigned o);
        int unsigned lim;
        lim = 32'd1 << w;
        if (total >= lim) begin
            o = 1;
`ifdef ACC_SATURATE_EN
            s = lim - 1;
`else
            s = total % lim;
`endif
        end else begin
            o = 0;
            s = total;
        end
        a = (s / COUNT) % 256;
    endfunction

    always @(posedge clk) begin
        int unsigned total;
        if (rst) begin
            m_hold = 1'b0;
            m_valid = 1'b0;
            q.delete();
            for (int i = 0; i < 2; i++) begin
                m_sum[i] = 0; m_avg[i] = 0; m_ovf[i] = 0;
            end
        end else if (!m_hold) begin
            if (in_valid) begin
                q.push_back(in_data);
                if (q.size() == COUNT) begin
                    total = 0;
                    foreach (q[i]) total += q[i];
                    calc(total, 10, m_sum[0], m_avg[0], m_ovf[0]);
                    calc(total, 9, m_sum[1], m_avg[1], m_ovf[1]);
                    m_valid = 1'b1;
                    m_hold = 1'b1;
                    q.delete();
                end
            end
        end else if (out_ready) begin
            m_valid = 1'b0;
            m_hold = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready_a", in_ready_a, !m_hold);
            chk("out_valid_a", out_valid_a, m_valid);
            chk("fill_a", fill_a, q.size());
            chk("out_sum_a", out_sum_a, m_sum[0]);
            chk("out_avg_a", out_avg_a, m_avg[0]);
            chk("out_ovf_a", out_ovf_a, m_ovf[0]);
            chk("in_ready_b", in_ready_b, !m_hold);
            chk("out_valid_b", out_valid_b, m_valid);
            chk("fill_b", fill_b, q.size());
            chk("out_sum_b", out_sum_b, m_sum[1]);
            chk("out_avg_b", out_avg_b, m_avg[1]);
            chk("out_ovf_b", out_ovf_b, m_ovf[1]);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Present a sample and hold it until accepted; waits = cycles spent stalled.
    task automatic send(input logic [7:0] d, output int waits);
        waits = 0;
        in_valid = 1'b1;
        in_data = d;
        forever begin
            @(negedge clk);
            if (in_ready_a) break;
            waits++;
            if (waits > 50) begin
                chk("send_timeout", waits, 0);
                break;
            end
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic send4(input logic [7:0] a, b, c, d);
        int w;
        send(a, w); send(b, w); send(c, w); send(d, w);
    endtask

    initial begin
        int w;
        step();
        chk_en = 1'b1;
        chk("reset_out_valid", out_valid_a, 0);
        chk("reset_fill", fill_a, 0);
        step();
        rst = 1'b0;

        // Basic window
        send4(8'd10, 8'd20, 8'd30, 8'd40);
        chk("t1_valid", out_valid_a, 1);
        chk("t1_sum", out_sum_a, 100);
        chk("t1_avg", out_avg_a, 25);
        chk("t1_ovf", out_ovf_a, 0);
        step();
        chk("t1_valid_one_cycle", out_valid_a, 0);

        // Backpressure
        out_ready = 1'b0;
        send4(8'd1, 8'd2, 8'd3, 8'd4);
        in_valid = 1'b1;
        in_data = 8'd50;
        repeat (5) begin
            @(negedge clk);
            chk("t2_in_ready_low", in_ready_a, 0);
            chk("t2_sum_stable", out_sum_a, 10);
        end
        step();
        out_ready = 1'b1;
        send(8'd50, w);
        chk("t2_bubble", w, 1);
        chk("t2_fill", fill_a, 1);
        send(8'd50, w); send(8'd50, w); send(8'd50, w);
        chk("t2_sum2", out_sum_a, 200);
        step();

        // Overflow on the 9-bit instance
        send4(8'd255, 8'd255, 8'd255, 8'd255);
        chk("t3_sum10", out_sum_a, 1020);
        chk("t3_ovf10", out_ovf_a, 0);
`ifdef ACC_SATURATE_EN
        chk("t3_sum9", out_sum_b, 511);
`else
        chk("t3_sum9", out_sum_b, 508);
`endif
        chk("t3_avg9", out_avg_b, 127);
        chk("t3_ovf9", out_ovf_b, 1);
        step();

        // Reset mid-window
        send(8'd7, w); send(8'd9, w);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_valid_in_rst", out_valid_a, 0);
        step();
        rst = 1'b0;
        chk("t4_fill_after_rst", fill_a, 0);
        send4(8'd1, 8'd1, 8'd1, 8'd1);
        chk("t4_sum", out_sum_a, 4);
        step();

        // Sparse input
        send(8'd5, w);
        send(8'd0, w);
        step(); step();
        send(8'd0, w);
        step(); step(); step();
        chk("t5_fill_idle", fill_a, 3);
        send(8'd255, w);
        chk("t5_sum", out_sum_a, 260);
        chk("t5_avg", out_avg_a, 65);
        chk("t5_sum9", out_sum_b, 260);
        step();

        // Drain and new sample offered in the same cycle
        out_ready = 1'b0;
        send4(8'd1, 8'd2, 8'd3, 8'd4);
        out_ready = 1'b1;
        send(8'd99, w);
        chk("t6_not_same_cycle", w, 1);
        chk("t6_fill", fill_a, 1);
        send(8'd1, w); send(8'd1, w); send(8'd1, w);
        chk("t6_sum", out_sum_a, 102);
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
